send_buffer: RTL
================

SEND_BUFFER -- requirements
Module: send_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in 32-bit words; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL change on posedge clk only.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 snd  input  1  one-cycle strobe from the processor execute stage: push interface_data.
REQ-005 interface_data  input  32  word to send; SHALL be sampled only in cycles where snd=1.
REQ-006 clr_overflow  input  1  clears the sticky overflow flag.
REQ-007 tx_byte  output  8  byte presented to the transmitter.
REQ-008 tx_valid  output  1  tx_byte is valid.
REQ-009 tx_ready  input  1  transmitter accepts tx_byte when tx_valid=1 and tx_ready=1 (a transfer).
REQ-010 full  output  1  FIFO holds DEPTH words.
REQ-011 empty  output  1  FIFO holds 0 words and the serializer is IDLE.
REQ-012 overflow  output  1  sticky: a snd strobe was dropped.
REQ-013 words_pending  output  $clog2(DEPTH)+1  number of words in the FIFO, excluding the word in the serializer.

Function
REQ-014 Push: a snd strobe SHALL write interface_data at the tail when the FIFO is not full, or when full and a pop occurs in the same cycle.
REQ-015 A snd strobe while full with no same-cycle pop SHALL be dropped, SHALL NOT modify FIFO contents, and SHALL set overflow on the next edge.
REQ-016 overflow SHALL clear on the edge after clr_overflow=1; a simultaneous drop and clr_overflow SHALL leave overflow=1 (set wins).
REQ-017 Pointers SHALL be $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full/empty SHALL be derived from the MSB-differs/equal comparison.
REQ-018 Serializer FSM states: IDLE, SEND. IDLE: tx_valid=0; if the FIFO is non-empty, pop the head into a 32-bit shift register, set byte_idx=0, and go to SEND.
REQ-019 SEND: tx_valid=1; tx_byte = byte byte_idx of the word, little-endian ([7:0] first, [31:24] last).
REQ-020 tx_byte SHALL hold stable while tx_valid=1 and tx_ready=0; tx_valid SHALL NOT drop before a transfer.
REQ-021 Each transfer SHALL increment byte_idx (2 bits). On the transfer of byte 3: if the FIFO is non-empty, pop the next word and stay in SEND with byte_idx=0 (no bubble); otherwise go to IDLE.
REQ-022 Latency: a snd in cycle N into an empty block SHALL give tx_valid=1 with byte 0 in cycle N+2.
REQ-023 Throughput: with tx_ready held at 1, one byte SHALL transfer per cycle and back-to-back words SHALL be contiguous.
REQ-024 Simultaneous push and pop SHALL leave words_pending unchanged.
REQ-025 empty=1 only when words_pending=0 and state=IDLE; full=1 iff words_pending=DEPTH.

Reset
REQ-026 When rst_n=0 on an edge: pointers=0, state=IDLE, byte_idx=0, shift register=0, overflow=0.
REQ-027 Following that reset edge, outputs SHALL be tx_valid=0, tx_byte=0, full=0, empty=1, overflow=0, words_pending=0.
REQ-028 Reset mid-word SHALL discard the in-flight word and all queued words; no partial word SHALL resume after reset.
REQ-029 FIFO storage need not be reset; the pointer reset alone SHALL invalidate it.

Structure
REQ-030 The state enum (IDLE, SEND) and the constant SEND_DEPTH=8 SHALL live in the shared processor package.
REQ-031 FIFO storage and pointers SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated once; the FSM and serializer SHALL live in send_buffer.

Verification
REQ-032 Single word: snd with 0xDDCCBBAA and tx_ready=1 -> tx_valid from cycle N+2, bytes AA,BB,CC,DD on 4 consecutive cycles, then empty=1.
REQ-033 Backpressure: tx_ready=0 for 5 cycles after tx_valid rises -> tx_byte held at AA throughout; resume -> exact byte order, no duplicates.
REQ-034 Overflow: tx_ready=0, 10 snd strobes with words 1..10 (DEPTH=8) -> 1 word in the serializer, 8 in the FIFO, word 10 dropped, full=1, overflow=1. Then tx_ready=1 -> words 1..9 emerge; clr_overflow -> overflow=0.
REQ-035 Full with simultaneous pop: FIFO full and snd in the cycle byte 3 transfers -> word accepted, words_pending stays 8, overflow stays 0.
REQ-036 Wrap-around: 20 words pushed and drained in 3 bursts -> all 80 bytes in order, pointers wrapped, words_pending returns to 0.
REQ-037 Reset mid-word: rst_n=0 after byte 1 -> tx_valid=0 after the reset edge, empty=1; next snd 0x11223344 -> bytes 44,33,22,11 only.

Source files
------------

// File: rtl/send_buffer_pkg.sv
// Shared processor-side definitions for the send buffer: serializer states and default depth.
package send_buffer_pkg;

    localparam int SEND_DEPTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/send_buffer_if.sv
// Processor/transmitter-facing signal bundle of send_buffer; slave = the buffer, master = its environment.
interface send_buffer_if import send_buffer_pkg::*; #(
    parameter int DEPTH = SEND_DEPTH
);
    logic                   snd;
    logic [31:0]            interface_data;
    logic                   clr_overflow;
    logic [7:0]             tx_byte;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic [$clog2(DEPTH):0] words_pending;

    modport master (
        output snd, interface_data, clr_overflow, tx_ready,
        input  tx_byte, tx_valid, full, empty, overflow, words_pending
    );

    modport slave (
        input  snd, interface_data, clr_overflow, tx_ready,
        output tx_byte, tx_valid, full, empty, overflow, words_pending
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is read combinationally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A push while full is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wptr_d = wptr_q + (AW+1)'(do_push);
    assign rptr_d = rptr_q + (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/send_buffer.sv
// Word FIFO feeding a little-endian byte serializer towards the transmitter, with sticky overflow.
module send_buffer import send_buffer_pkg::*; #(
    parameter int DEPTH = SEND_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    send_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    ser_state_e  state_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] shreg_q;
    logic        ovf_q;

    logic [31:0] fifo_rdata;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    logic        xfer, last_xfer, pop, drop;

    assign xfer      = (state_q == SEND) && bus.tx_ready;
    assign last_xfer = xfer && (byte_idx_q == 2'd3);
    // Refill from IDLE, or straight after byte 3 so consecutive words have no gap.
    assign pop       = !fifo_empty && ((state_q == IDLE) || last_xfer);
    assign drop      = bus.snd && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.snd),
        .pop_i   (pop),
        .wdata_i (bus.interface_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            shreg_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (drop)                  ovf_q <= 1'b1;
            else if (bus.clr_overflow) ovf_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shreg_q    <= fifo_rdata;
                        byte_idx_q <= 2'd0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (pop) begin
                            shreg_q    <= fifo_rdata;
                            byte_idx_q <= 2'd0;
                        end else begin
                            // Shifting right keeps the current byte at [7:0].
                            shreg_q    <= {8'h00, shreg_q[31:8]};
                            byte_idx_q <= byte_idx_q + 2'd1;
                            if (last_xfer) state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_valid      = (state_q == SEND);
    assign bus.tx_byte       = shreg_q[7:0];
    assign bus.full          = fifo_full;
    assign bus.empty         = fifo_empty && (state_q == IDLE);
    assign bus.overflow      = ovf_q;
    assign bus.words_pending = fifo_count;

endmodule
